// File: rtl/int_fp_pkg.sv
// int_fp_pkg: shared widths, float word layout and helpers for the int/fp conversion datapath
package int_fp_pkg;
  localparam int INT_W = 8;
  localparam int EXP_W = 4;
  localparam int FRAC_W = 8;
  localparam int POS_W = 3;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;
  function automatic fp_t fp_zero();
    return '0;
  endfunction
endpackage

// File: rtl/lead_one_det.sv
// lead_one_det: priority encoder giving the index of the most-significant set bit of the magnitude
module lead_one_det
  import int_fp_pkg::*;
(
  input  logic [INT_W-2:0] mag,
  output logic [POS_W-1:0] pos,
  output logic             any_one
);
  always_comb begin
    any_one = |mag;
    pos = mag[6] ? 3'd6 :
          mag[5] ? 3'd5 :
          mag[4] ? 3'd4 :
          mag[3] ? 3'd3 :
          mag[2] ? 3'd2 :
          mag[1] ? 3'd1 : 3'd0;
  end
endmodule

// File: rtl/int_to_fp_conv.sv
// int_to_fp_conv: registered sign-magnitude integer to normalized float conversion with valid strobe
module int_to_fp_conv
  import int_fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [INT_W-1:0]  integ,
  output logic              out_valid,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac
);
  logic [INT_W-2:0] mag;
  logic [POS_W-1:0] pos;
  logic any_one;
  logic [FRAC_W-1:0] frac_n;
  fp_t res, q;
  assign mag = integ[INT_W-2:0];
  lead_one_det u_lod (
    .mag(mag),
    .pos(pos),
    .any_one(any_one)
  );
  always_comb begin
    frac_n = {mag, 1'b0} << (POS_W'(INT_W-2) - pos);
    res.sign = any_one & integ[INT_W-1];
    res.exp = any_one ? EXP_W'({1'b0, pos}) + EXP_W'(1) : '0;
    res.frac = any_one ? frac_n : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= fp_zero();
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) q <= res;
    end
  end
  assign sign = q.sign;
  assign exp = q.exp;
  assign frac = q.frac;
endmodule

// File: tb/tb_int_to_fp_conv.sv
// tb_int_to_fp_conv: directed and exhaustive checks of the int to float conversion stage
module tb_int_to_fp_conv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] integ = 8'h00;
  logic out_valid, sign;
  logic [3:0] exp;
  logic [7:0] frac;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  int_to_fp_conv dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .integ(integ),
    .out_valid(out_valid),
    .sign(sign),
    .exp(exp),
    .frac(frac)
  );
  function automatic logic [12:0] model(input logic [7:0] v);
    logic [7:0] f;
    logic [3:0] e;
    if (v[6:0] == 7'd0) return 13'd0;
    f = {v[6:0], 1'b0};
    e = 4'd7;
    while (!f[7]) begin
      f = f << 1;
      e = e - 4'd1;
    end
    return {v[7], e, f};
  endfunction
  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    integ = d;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [13:0] obs();
    return {out_valid, sign, exp, frac};
  endfunction
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h05);
      check("reset", obs(), 14'd0);
    end
    rst_n = 1'b1;
    step(1'b1, 8'h05);
    check("post_reset_05", obs(), {1'b1, 1'b0, 4'b0011, 8'b1010_0000});
    step(1'b1, 8'h00);
    check("zero_00", obs(), {1'b1, 13'd0});
    step(1'b1, 8'h80);
    check("neg_zero_80", obs(), {1'b1, 13'd0});
    step(1'b1, 8'h01);
    check("ext_01", obs(), {1'b1, 1'b0, 4'b0001, 8'b1000_0000});
    step(1'b1, 8'h7F);
    check("ext_7f", obs(), {1'b1, 1'b0, 4'b0111, 8'b1111_1110});
    step(1'b1, 8'h81);
    check("ext_81", obs(), {1'b1, 1'b1, 4'b0001, 8'b1000_0000});
    step(1'b1, 8'hFF);
    check("ext_ff", obs(), {1'b1, 1'b1, 4'b0111, 8'b1111_1110});
    step(1'b1, 8'h40);
    check("pow_40", obs(), {1'b1, 1'b0, 4'b0111, 8'b1000_0000});
    step(1'b1, 8'hA0);
    check("pow_a0", obs(), {1'b1, 1'b1, 4'b0110, 8'b1000_0000});
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      int d, want_val, got_val;
      v = 8'(i);
      step(1'b1, v);
      check("sweep", obs(), {1'b1, model(v)});
      if (v[6:0] != 7'd0) check("sweep_msb", 14'(frac[7]), 14'd1);
      d = (int'(frac) << exp) >> 8;
      got_val = sign ? -d : d;
      want_val = v[7] ? -int'(v[6:0]) : int'(v[6:0]);
      check("sweep_decode", 14'(got_val), 14'(want_val));
    end
    step(1'b1, 8'h33);
    check("gap_33", obs(), {1'b1, 1'b0, 4'b0110, 8'b1100_1100});
    step(1'b0, 8'h12);
    check("gap_hold_33", obs(), {1'b0, 1'b0, 4'b0110, 8'b1100_1100});
    step(1'b1, 8'h12);
    check("gap_12", obs(), {1'b1, 1'b0, 4'b0101, 8'b1001_0000});
    step(1'b0, 8'h33);
    check("gap_hold_12", obs(), {1'b0, 1'b0, 4'b0101, 8'b1001_0000});
    step(1'b1, 8'h33);
    check("gap_33_again", obs(), {1'b1, 1'b0, 4'b0110, 8'b1100_1100});
    rst_n = 1'b0;
    step(1'b1, 8'hFF);
    check("reset_midstream", obs(), 14'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
